shift_unit_seq: RTL and testbench



---
 rtl/shift_unit_seq.sv | 194 +++++++++++++++++++
 tb/tb_shift_unit_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle logarithmic shifter (SLL / SRA / SRL / ROR).
// One log-shifter stage is applied per clock, behind valid/ready handshakes
// on both sides, so the ALU result path no longer carries a barrel shifter.
// Optional build macro: SHIFT_UNIT_SKIP_EN -- when defined, stages whose
// shift-amount bit is 0 are skipped and latency becomes popcount(shamt).
module shift_unit_seq #(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_shamt,
    input  logic [1:0]                 in_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_carry,
    output logic                       out_zero
);

    localparam int SHAMT_W = $clog2(WIDTH);
    // Stage index selects one bit of the shift amount.
    localparam int CNT_W   = $clog2(SHAMT_W);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_SRL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    logic [1:0]         state;
    logic [WIDTH-1:0]   work_q;
    logic [WIDTH-1:0]   orig_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic [1:0]         mode_q;
    logic               sign_q;
`ifdef SHIFT_UNIT_SKIP_EN
    logic [SHAMT_W-1:0] rem_q;
    logic [SHAMT_W-1:0] rem_next;
`else
    logic [CNT_W-1:0]   cnt_q;
`endif

    logic [CNT_W-1:0]   stage_k;
    logic               stage_apply;
    logic [WIDTH-1:0]   shifted;
    logic               last_stage;

    // One log-shifter stage: move v by 2^k positions according to mode.
    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] v,
        input logic [CNT_W-1:0] k,
        input logic [1:0]       mode,
        input logic             sign
    );
        logic [SHAMT_W:0] amt;
        logic [SHAMT_W:0] ramt;
        logic [WIDTH-1:0] fill;
        amt  = (SHAMT_W+1)'(1) << k;
        ramt = (SHAMT_W+1)'(WIDTH) - amt;
        fill = ~({WIDTH{1'b1}} >> amt);
        case (mode)
            MODE_SLL: stage_shift = v << amt;
            MODE_SRA: stage_shift = (v >> amt) | (sign ? fill : '0);
            MODE_SRL: stage_shift = v >> amt;
            default:  stage_shift = (v >> amt) | (v << ramt);
        endcase
    endfunction

    // Last bit moved out of the operand for a total shift of s.
    function automatic logic carry_of(
        input logic [WIDTH-1:0]   orig,
        input logic [SHAMT_W-1:0] s,
        input logic [1:0]         mode,
        input logic [WIDTH-1:0]   result
    );
        logic [SHAMT_W-1:0] idx;
        carry_of = 1'b0;
        idx      = '0;
        if (s != '0) begin
            case (mode)
                MODE_SLL: begin
                    // WIDTH - s, taken modulo WIDTH (s is never 0 here).
                    idx      = ~s + 1'b1;
                    carry_of = orig[idx];
                end
                MODE_SRA, MODE_SRL: begin
                    idx      = s - 1'b1;
                    carry_of = orig[idx];
                end
                MODE_ROR: carry_of = result[WIDTH-1];
                default:  carry_of = 1'b0;
            endcase
        end
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Select the stage for this SHIFT cycle and compute its output.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the block leaves it unassigned and infers a latch.
`ifdef SHIFT_UNIT_SKIP_EN
        stage_k = '0;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (rem_q[i]) stage_k = CNT_W'(i);
        end
        stage_apply = 1'b1;
        rem_next    = rem_q & ~(SHAMT_W'(1) << stage_k);
        last_stage  = (rem_next == '0);
`else
        stage_k     = cnt_q;
        stage_apply = shamt_q[stage_k];
        last_stage  = (cnt_q == '0);
`endif
        shifted = stage_apply ? stage_shift(work_q, stage_k, mode_q, sign_q) : work_q;
    end

    // Control FSM and registered result; synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state     <= IDLE;
            out_data  <= '0;
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifdef SHIFT_UNIT_SKIP_EN
                        if (in_shamt == '0) begin
                            state     <= DONE;
                            out_data  <= in_data;
                            out_carry <= 1'b0;
                            out_zero  <= ~|in_data;
                        end else begin
                            state <= SHIFT;
                        end
`else
                        state <= SHIFT;
`endif
                    end
                end
                SHIFT: begin
                    if (last_stage) begin
                        state     <= DONE;
                        out_data  <= shifted;
                        out_carry <= carry_of(orig_q, shamt_q, mode_q, shifted);
                        out_zero  <= ~|shifted;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Working datapath registers; their contents are only meaningful while
    // an operation is in flight, so they are loaded on acceptance.
    always_ff @(posedge clk) begin
        // NOTE: these registers carry no reset; the FSM never reads them
        // before an acceptance has loaded them.
        if (state == IDLE && in_valid) begin
            work_q  <= in_data;
            orig_q  <= in_data;
            shamt_q <= in_shamt;
            mode_q  <= in_mode;
            sign_q  <= in_data[WIDTH-1];
`ifdef SHIFT_UNIT_SKIP_EN
            rem_q   <= in_shamt;
`else
            cnt_q   <= CNT_W'(SHAMT_W - 1);
`endif
        end else if (state == SHIFT) begin
            work_q <= shifted;
`ifdef SHIFT_UNIT_SKIP_EN
            rem_q  <= rem_next;
`else
            cnt_q  <= cnt_q - 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// tb_shift_unit_seq: scoreboard bench for shift_unit_seq (WIDTH=16).
// The driver pushes the expected result of every accepted request; an
// independent monitor pops and compares whenever out_valid rises, and keeps
// checking the held result while backpressure is applied.
module tb_shift_unit_seq;

    localparam int WIDTH   = 16;
    localparam int SHAMT_W = 4;

    typedef struct {
        logic [15:0] data;
        logic        carry;
        logic        zero;
        int          lat;
        int          e0;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_shamt;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_carry;
    logic        out_zero;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb[$];
    exp_t cur_exp;
    logic holding  = 1'b0;
    logic force_bp = 1'b0;

    shift_unit_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: whole shift done at once with integer arithmetic.
    function automatic exp_t model(input logic [15:0] d, input int s, input logic [1:0] m);
        exp_t e;
        int v, sv, r, c;
        v  = int'(d);
        sv = int'($signed(d));
        case (m)
            2'b00: begin r = (v << s) & 'hFFFF;  c = (s == 0) ? 0 : (v >> (16 - s)) & 1; end
            2'b01: begin r = (sv >>> s) & 'hFFFF; c = (s == 0) ? 0 : (v >> (s - 1)) & 1; end
            2'b10: begin r = v >> s;             c = (s == 0) ? 0 : (v >> (s - 1)) & 1; end
            default: begin
                r = ((v >> s) | (v << (16 - s))) & 'hFFFF;
                c = (s == 0) ? 0 : (r >> 15) & 1;
            end
        endcase
        e.data  = 16'(r);
        e.carry = (c != 0);
        e.zero  = (r == 0);
`ifdef SHIFT_UNIT_SKIP_EN
        e.lat   = $countones(s[3:0]);
`else
        e.lat   = SHAMT_W;
`endif
        e.e0    = 0;
        return e;
    endfunction

    // Issue one request and record its expected result at acceptance.
    task automatic send(input logic [15:0] d, input logic [3:0] s, input logic [1:0] m);
        exp_t e;
        int guard = 0;
        while (!in_ready) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 200) begin
                check("in_ready_timeout", 32'(in_ready), 32'd1);
                return;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_mode  = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e    = model(d, int'(s), m);
        e.e0 = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_valid();
        int guard = 0;
        while (!out_valid) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 50) begin
                check("out_valid_timeout", 32'(out_valid), 32'd1);
                return;
            end
        end
    endtask

    // Consumer readiness: random unless a test forces backpressure.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!force_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare on out_valid rise, then hold-stability until handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            holding = 1'b0;
        end else begin
            if (out_valid && !holding) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    cur_exp = sb.pop_front();
                    check("data",    32'(out_data),  32'(cur_exp.data));
                    check("carry",   32'(out_carry), 32'(cur_exp.carry));
                    check("zero",    32'(out_zero),  32'(cur_exp.zero));
                    check("latency", 32'(cyc - cur_exp.e0), 32'(cur_exp.lat));
                    holding = 1'b1;
                end
            end else if (out_valid && holding) begin
                check("hold_data",  32'(out_data),  32'(cur_exp.data));
                check("hold_carry", 32'(out_carry), 32'(cur_exp.carry));
                check("hold_ready", 32'(in_ready),  32'd0);
            end
            if (out_valid && out_ready) holding = 1'b0;
        end
    end

    logic [15:0] dir_d [12] = '{16'h0001, 16'h8008, 16'h8000, 16'h8000, 16'h1234, 16'h0001,
                                16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hA5C3, 16'hA5C3};
    logic [3:0]  dir_s [12] = '{4'd15, 4'd4, 4'd15, 4'd1, 4'd8, 4'd1,
                                4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd15};
    logic [1:0]  dir_m [12] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 2'b11,
                                2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b11};

    initial begin
        int guard;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_shamt = '0;
        in_mode  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_carry", 32'(out_carry), 32'd0);
        check("rst_out_zero",  32'(out_zero),  32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed cases, including shamt=0 and the latency corners.
        for (int i = 0; i < 12; i++) send(dir_d[i], dir_s[i], dir_m[i]);

        // Backpressure: result held for 10 cycles, new requests ignored.
        guard = 0;
        while ((sb.size() != 0 || holding) && guard < 200) begin @(posedge clk); #1; guard++; end
        force_bp  = 1'b1;
        out_ready = 1'b0;
        send(16'h1234, 4'd8, 2'b11);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 16'h00FF;
            in_shamt = 4'd3;
            in_mode  = 2'b00;
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready),  32'd1);
        force_bp = 1'b0;
        send(16'h00F0, 4'd2, 2'b10);

        // Reset during SHIFT abandons the operation.
        guard = 0;
        while ((sb.size() != 0 || holding) && guard < 200) begin @(posedge clk); #1; guard++; end
        send(16'h4321, 4'd15, 2'b00);
        @(posedge clk); #1;
        sb.delete();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data",  32'(out_data),  32'd0);
        check("midrst_out_carry", 32'(out_carry), 32'd0);
        check("midrst_out_zero",  32'(out_zero),  32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        repeat (8) @(posedge clk);
        #1;

        // Randomised traffic with random consumer backpressure.
        for (int i = 0; i < 150; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if (i % 10 == 0) d = 16'h0000;
            if (i % 10 == 1) d = 16'hFFFF;
            send(d, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        end

        guard = 0;
        while ((sb.size() != 0 || holding) && guard < 200) begin @(posedge clk); #1; guard++; end
        check("drain_pending", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
